serv_irq_arb: RTL and testbench

SERV_IRQ_ARB -- requirements
Module: serv_irq_arb

---
 rtl/serv_irq_arb_if.sv | 29 ++
 rtl/serv_irq_arb.sv | 122 ++++++++++++
 tb/tb_serv_irq_arb.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serv_irq_arb_if.sv
// Core-side interrupt bundle for serv_irq_arb: pending/enable lines, trap handshake and serial cause.
interface serv_irq_arb_if;
  logic       i_msip;
  logic       i_mtip;
  logic       i_meip;
  logic       i_msie;
  logic       i_mtie;
  logic       i_meie;
  logic       i_mstatus_mie;
  logic       i_irq_ack;
  logic       i_mret;
  logic       i_cause_shift;
  logic       o_irq_req;
  logic       o_cause_q;
  logic [3:0] o_cause;
  logic       o_irq_active;

  modport master (
    output i_msip, i_mtip, i_meip, i_msie, i_mtie, i_meie, i_mstatus_mie,
    output i_irq_ack, i_mret, i_cause_shift,
    input  o_irq_req, o_cause_q, o_cause, o_irq_active
  );

  modport slave (
    input  i_msip, i_mtip, i_meip, i_msie, i_mtie, i_meie, i_mstatus_mie,
    input  i_irq_ack, i_mret, i_cause_shift,
    output o_irq_req, o_cause_q, o_cause, o_irq_active
  );
endinterface

// File: rtl/serv_irq_arb.sv
// Machine interrupt arbiter: priority pick, trap request handshake, post-mret hold-off, serial cause.
// Define SERV_IRQ_EXT_EN to let the external interrupt (cause 11) take part in arbitration.
module serv_irq_arb #(
  parameter              RESET_STRATEGY = "MINI",
  parameter int unsigned HOLDOFF        = 2
) (
  input logic          i_clk,
  input logic          i_rst_n,
  serv_irq_arb_if.slave bus
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CAUSE_W = 4;
  localparam logic [CAUSE_W-1:0] CAUSE_SW  = CAUSE_W'(3);
  localparam logic [CAUSE_W-1:0] CAUSE_TM  = CAUSE_W'(7);
  localparam logic [CAUSE_W-1:0] CAUSE_EXT = CAUSE_W'(11);
  localparam bit RESET_ALL = (RESET_STRATEGY != "NONE");

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HANDLER, S_HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               irq_req;
  logic               irq_active;
  logic [CAUSE_W-1:0] cause_r;
  logic [CAUSE_W-1:0] sr;

  logic               sw_elig;
  logic               tm_elig;
  logic               ext_elig;
  logic               any_elig;
  logic               latched_elig;
  logic [CAUSE_W-1:0] win_cause;

  assign sw_elig = bus.i_msip & bus.i_msie & bus.i_mstatus_mie;
  assign tm_elig = bus.i_mtip & bus.i_mtie & bus.i_mstatus_mie;

`ifdef SERV_IRQ_EXT_EN
  assign ext_elig = bus.i_meip & bus.i_meie & bus.i_mstatus_mie;
`else
  logic unused_ext;
  assign ext_elig   = 1'b0;
  assign unused_ext = bus.i_meip ^ bus.i_meie;
`endif

  // Fixed priority ext > sw > timer; latched_elig tracks the source already being requested.
  always_comb begin
    win_cause    = CAUSE_TM;
    latched_elig = 1'b0;
    any_elig     = ext_elig | sw_elig | tm_elig;
    if (ext_elig)     win_cause = CAUSE_EXT;
    else if (sw_elig) win_cause = CAUSE_SW;
    case (cause_r)
      CAUSE_EXT: latched_elig = ext_elig;
      CAUSE_SW:  latched_elig = sw_elig;
      CAUSE_TM:  latched_elig = tm_elig;
      default:   latched_elig = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      irq_req    <= 1'b0;
      irq_active <= 1'b0;
      cnt        <= '0;
      if (RESET_ALL) begin
        cause_r <= '0;
        sr      <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (cnt == '0 && any_elig) begin
            state   <= S_REQ;
            irq_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.i_irq_ack) begin
            state      <= S_HANDLER;
            irq_req    <= 1'b0;
            irq_active <= 1'b1;
          end else if (!latched_elig) begin
            state   <= S_IDLE;
            irq_req <= 1'b0;
          end
        end
        S_HANDLER: begin
          if (bus.i_mret) begin
            state      <= S_HOLD;
            irq_active <= 1'b0;
            cnt        <= CNT_W'(HOLDOFF);
          end
        end
        S_HOLD: begin
          // Leave on the edge the count steps down to 1; the IDLE cycle that follows is the last quiet one.
          if (cnt <= CNT_W'(2)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase

      if (state == S_IDLE && cnt == '0 && any_elig) begin
        cause_r <= win_cause;
        sr      <= win_cause;
      end else if (bus.i_cause_shift) begin
        sr <= {1'b0, sr[CAUSE_W-1:1]};
      end
    end
  end

  assign bus.o_irq_req    = irq_req;
  assign bus.o_irq_active = irq_active;
  assign bus.o_cause      = cause_r;
  assign bus.o_cause_q    = sr[0];

endmodule

// File: tb/tb_serv_irq_arb.sv
// Self-checking bench for serv_irq_arb: directed scenarios plus randomized run against a reference model.
module tb_serv_irq_arb;
  localparam int unsigned HOLDOFF = 2;
`ifdef SERV_IRQ_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  serv_irq_arb_if bif ();

  serv_irq_arb #(
    .RESET_STRATEGY("MINI"),
    .HOLDOFF       (HOLDOFF)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bif)
  );

  always #5 clk = ~clk;

  // Reference model: request/handler flags, quiet cycles left after mret, latched code and shift value.
  bit m_req    = 1'b0;
  bit m_active = 1'b0;
  int m_wait   = 0;
  int m_cause  = 0;
  int m_sr     = 0;

  function automatic bit src_elig(int code);
    if (bif.i_mstatus_mie !== 1'b1) return 1'b0;
    case (code)
      11:      return EXT && bif.i_meip === 1'b1 && bif.i_meie === 1'b1;
      3:       return bif.i_msip === 1'b1 && bif.i_msie === 1'b1;
      7:       return bif.i_mtip === 1'b1 && bif.i_mtie === 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int pick();
    if (src_elig(11)) return 11;
    if (src_elig(3))  return 3;
    if (src_elig(7))  return 7;
    return 0;
  endfunction

  always @(posedge clk) begin : ref_model
    int win;
    bit load;
    win  = pick();
    load = 1'b0;
    if (!rst_n) begin
      m_req = 1'b0; m_active = 1'b0; m_wait = 0; m_cause = 0; m_sr = 0;
    end else begin
      if (m_req) begin
        if (bif.i_irq_ack) begin
          m_req = 1'b0; m_active = 1'b1;
        end else if (!src_elig(m_cause)) begin
          m_req = 1'b0;
        end
      end else if (m_active) begin
        if (bif.i_mret) begin
          m_active = 1'b0;
          // HOLDOFF quiet cycles in total: the hold cycles plus one arbitration cycle in idle.
          m_wait = (HOLDOFF > 1) ? int'(HOLDOFF) - 1 : 1;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (win != 0) begin
        m_req = 1'b1; m_cause = win; load = 1'b1;
      end
      if (load)                  m_sr = win;
      else if (bif.i_cause_shift) m_sr = m_sr >> 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bif.i_msip = 0; bif.i_mtip = 0; bif.i_meip = 0;
    bif.i_msie = 0; bif.i_mtie = 0; bif.i_meie = 0;
    bif.i_mstatus_mie = 0; bif.i_irq_ack = 0; bif.i_mret = 0; bif.i_cause_shift = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    bif.i_mtip = 1; bif.i_mtie = 1; bif.i_mstatus_mie = 1; bif.i_irq_ack = 1;
    rst_n = 1'b0;
    cyc();
    n_cmp++; if (bif.o_irq_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", bif.o_irq_req); end
    n_cmp++; if (bif.o_irq_active !== 1'b0) begin n_err++; $display("FAIL reset_active got=%b exp=0", bif.o_irq_active); end
    n_cmp++; if (bif.o_cause !== 4'd0) begin n_err++; $display("FAIL reset_cause got=%0d exp=0", bif.o_cause); end
    n_cmp++; if (bif.o_cause_q !== 1'b0) begin n_err++; $display("FAIL reset_cause_q got=%b exp=0", bif.o_cause_q); end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_timer();
    do_reset();
    bif.i_mtip = 1; bif.i_mtie = 1; bif.i_mstatus_mie = 1;
    cyc();
    n_cmp++; if (bif.o_irq_req !== 1'b1) begin n_err++; $display("FAIL timer_req got=%b exp=1", bif.o_irq_req); end
    n_cmp++; if (bif.o_cause !== 4'd7) begin n_err++; $display("FAIL timer_cause got=%0d exp=7", bif.o_cause); end
    bif.i_msip = 1; bif.i_msie = 1;
    cyc();
    n_cmp++; if (bif.o_cause !== 4'd7) begin n_err++; $display("FAIL timer_cause_frozen got=%0d exp=7", bif.o_cause); end
    bif.i_irq_ack = 1;
    cyc();
    bif.i_irq_ack = 0;
    n_cmp++; if (bif.o_irq_active !== 1'b1) begin n_err++; $display("FAIL timer_active got=%b exp=1", bif.o_irq_active); end
    n_cmp++; if (bif.o_irq_req !== 1'b0) begin n_err++; $display("FAIL timer_req_handler got=%b exp=0", bif.o_irq_req); end
  endtask

  task automatic test_priority();
    logic [3:0] exp;
    exp = EXT ? 4'd11 : 4'd3;
    do_reset();
    bif.i_msip = 1; bif.i_mtip = 1; bif.i_meip = 1;
    bif.i_msie = 1; bif.i_mtie = 1; bif.i_meie = 1; bif.i_mstatus_mie = 1;
    cyc();
    n_cmp++; if (bif.o_irq_req !== 1'b1) begin n_err++; $display("FAIL prio_req got=%b exp=1", bif.o_irq_req); end
    n_cmp++; if (bif.o_cause !== exp) begin n_err++; $display("FAIL prio_cause got=%0d exp=%0d", bif.o_cause, exp); end
  endtask

  task automatic test_withdraw();
    do_reset();
    bif.i_mtip = 1; bif.i_mtie = 1; bif.i_mstatus_mie = 1;
    cyc();
    bif.i_mstatus_mie = 0;
    cyc();
    n_cmp++; if (bif.o_irq_req !== 1'b0) begin n_err++; $display("FAIL withdraw_req got=%b exp=0", bif.o_irq_req); end
    n_cmp++; if (bif.o_irq_active !== 1'b0) begin n_err++; $display("FAIL withdraw_active got=%b exp=0", bif.o_irq_active); end
    bif.i_mstatus_mie = 1;
    cyc();
    n_cmp++; if (bif.o_irq_req !== 1'b1) begin n_err++; $display("FAIL rearb_req got=%b exp=1", bif.o_irq_req); end
    bif.i_mstatus_mie = 0; bif.i_irq_ack = 1;
    cyc();
    bif.i_irq_ack = 0;
    n_cmp++; if (bif.o_irq_active !== 1'b1) begin n_err++; $display("FAIL ack_wins_active got=%b exp=1", bif.o_irq_active); end
    n_cmp++; if (bif.o_irq_req !== 1'b0) begin n_err++; $display("FAIL ack_wins_req got=%b exp=0", bif.o_irq_req); end
  endtask

  task automatic test_holdoff();
    do_reset();
    bif.i_mtip = 1; bif.i_mtie = 1; bif.i_mstatus_mie = 1;
    cyc();
    bif.i_irq_ack = 1;
    cyc();
    bif.i_irq_ack = 0;
    bif.i_mret = 1;
    cyc();
    bif.i_mret = 0;
    n_cmp++; if (bif.o_irq_req !== 1'b0) begin n_err++; $display("FAIL holdoff_c1 got=%b exp=0", bif.o_irq_req); end
    n_cmp++; if (bif.o_irq_active !== 1'b0) begin n_err++; $display("FAIL holdoff_active got=%b exp=0", bif.o_irq_active); end
    cyc();
    n_cmp++; if (bif.o_irq_req !== 1'b0) begin n_err++; $display("FAIL holdoff_c2 got=%b exp=0", bif.o_irq_req); end
    cyc();
    n_cmp++; if (bif.o_irq_req !== 1'b1) begin n_err++; $display("FAIL holdoff_c3 got=%b exp=1", bif.o_irq_req); end
  endtask

  task automatic test_shift();
    int c;
    c = EXT ? 11 : 3;
    do_reset();
    bif.i_mstatus_mie = 1;
    if (EXT) begin bif.i_meip = 1; bif.i_meie = 1; end
    else     begin bif.i_msip = 1; bif.i_msie = 1; end
    cyc();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (bif.o_cause_q !== 1'((c >> k) & 1)) begin
        n_err++; $display("FAIL shift_bit%0d got=%b exp=%0d", k, bif.o_cause_q, (c >> k) & 1);
      end
      bif.i_cause_shift = 1;
      cyc();
      bif.i_cause_shift = 0;
    end
    n_cmp++; if (bif.o_cause_q !== 1'b0) begin n_err++; $display("FAIL shift_tail got=%b exp=0", bif.o_cause_q); end
    n_cmp++; if (bif.o_cause !== 4'(c)) begin n_err++; $display("FAIL shift_cause got=%0d exp=%0d", bif.o_cause, c); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bif.i_mtip = 1; bif.i_mtie = 1; bif.i_mstatus_mie = 1;
    cyc();
    rst_n = 1'b0;
    cyc();
    n_cmp++; if (bif.o_irq_req !== 1'b0) begin n_err++; $display("FAIL midreq_req got=%b exp=0", bif.o_irq_req); end
    n_cmp++; if (bif.o_irq_active !== 1'b0) begin n_err++; $display("FAIL midreq_active got=%b exp=0", bif.o_irq_active); end
    n_cmp++; if (bif.o_cause !== 4'd0) begin n_err++; $display("FAIL midreq_cause got=%0d exp=0", bif.o_cause); end
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (bif.o_irq_req !== 1'b1) begin n_err++; $display("FAIL midreq_rearb got=%b exp=1", bif.o_irq_req); end
    bif.i_irq_ack = 1;
    cyc();
    bif.i_irq_ack = 0;
    rst_n = 1'b0;
    cyc();
    n_cmp++; if (bif.o_irq_active !== 1'b0) begin n_err++; $display("FAIL midhandler_active got=%b exp=0", bif.o_irq_active); end
    rst_n = 1'b1;
    bif.i_mstatus_mie = 0;
    cyc();
    n_cmp++; if (bif.o_irq_req !== 1'b0) begin n_err++; $display("FAIL post_reset_req got=%b exp=0", bif.o_irq_req); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bif.i_msip = ($urandom_range(0, 3) != 0);
      bif.i_mtip = ($urandom_range(0, 3) != 0);
      bif.i_meip = ($urandom_range(0, 3) == 0);
      bif.i_msie = ($urandom_range(0, 2) != 0);
      bif.i_mtie = ($urandom_range(0, 2) != 0);
      bif.i_meie = ($urandom_range(0, 2) != 0);
      bif.i_mstatus_mie = ($urandom_range(0, 7) != 0);
      bif.i_irq_ack = ($urandom_range(0, 2) == 0);
      bif.i_mret = ($urandom_range(0, 3) == 0);
      bif.i_cause_shift = ($urandom_range(0, 1) == 0);
      rst_n = ($urandom_range(0, 63) != 0);
      cyc();
      n_cmp++; if (bif.o_irq_req !== m_req) begin n_err++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, bif.o_irq_req, m_req); end
      n_cmp++; if (bif.o_irq_active !== m_active) begin n_err++; $display("FAIL rnd_active cyc=%0d got=%b exp=%b", i, bif.o_irq_active, m_active); end
      n_cmp++; if (bif.o_cause !== 4'(m_cause)) begin n_err++; $display("FAIL rnd_cause cyc=%0d got=%0d exp=%0d", i, bif.o_cause, m_cause); end
      n_cmp++; if (bif.o_cause_q !== 1'(m_sr & 1)) begin n_err++; $display("FAIL rnd_cause_q cyc=%0d got=%b exp=%0d", i, bif.o_cause_q, m_sr & 1); end
    end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_timer();
    test_priority();
    test_withdraw();
    test_holdoff();
    test_shift();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
